// File: rtl/text_tile_gen.sv
// Character-mode text renderer: 80x30 tile buffer with cursor write port,
// clear-screen sequencer and a 3-cycle pixel pipeline through an external font ROM.
module text_tile_gen #(
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000,
  parameter logic [6:0]  CLEAR_CHAR = 7'h20,
  parameter int          COLS       = 80,
  parameter int          ROWS       = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        video_on,
  output logic [10:0] font_addr,
  input  logic [7:0]  font_data,
  input  logic        wr_en,
  input  logic [6:0]  wr_char,
  input  logic        set_cur,
  input  logic [6:0]  cur_col_in,
  input  logic [4:0]  cur_row_in,
  input  logic        clr_req,
  output logic        busy,
  output logic [6:0]  cur_col,
  output logic [4:0]  cur_row,
  output logic        text_on,
  output logic [11:0] rgb,
  output logic        video_on_d
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state_q, state_d;
  logic [6:0]  clr_col;
  logic [4:0]  clr_row;
  logic        clear_last;
  logic        mem_we;
  logic [11:0] mem_waddr;
  logic [6:0]  mem_wdata;
  logic [6:0]  mem [0:4095];
  logic [6:0]  ram_q;
  logic [2:0]  x_p1, x_p2;
  logic [3:0]  y_p1;
  logic        vld_p1, vld_p2;
  logic        pix_bit;
  logic        unused_pix;

  // Next position in raster order {row, col}; wraps to the origin after the last cell.
  function automatic logic [11:0] advance(input logic [6:0] c, input logic [4:0] r);
    if (c != LAST_COL) return {r, c + 7'd1};
    if (r != LAST_ROW) return {r + 5'd1, 7'd0};
    return 12'd0;
  endfunction

  function automatic logic [6:0] clamp_col(input logic [6:0] c);
    return (c > LAST_COL) ? LAST_COL : c;
  endfunction

  function automatic logic [4:0] clamp_row(input logic [4:0] r);
    return (r > LAST_ROW) ? LAST_ROW : r;
  endfunction

  assign unused_pix = pix_y[9];
  assign clear_last = (clr_row == LAST_ROW) && (clr_col == LAST_COL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clr_req) state_d = CLEAR;
      CLEAR:   if (clear_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = {cur_row, cur_col};
    mem_wdata = wr_char;
    case (state_q)
      IDLE: mem_we = wr_en & ~set_cur & ~clr_req;
      CLEAR: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_waddr = {clr_row, clr_col};
        mem_wdata = CLEAR_CHAR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_col <= '0;
      cur_row <= '0;
      clr_col <= '0;
      clr_row <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            clr_col <= '0;
            clr_row <= '0;
          end else if (set_cur) begin
            cur_col <= clamp_col(cur_col_in);
            cur_row <= clamp_row(cur_row_in);
          end else if (wr_en) begin
            {cur_row, cur_col} <= advance(cur_col, cur_row);
          end
        end
        CLEAR: begin
          {clr_row, clr_col} <= advance(clr_col, clr_row);
          if (clear_last) begin
            cur_col <= '0;
            cur_row <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Stage p0 -> p1: tile lookup, pixel offsets and qualifier follow alongside.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ram_q <= '0;
    else       ram_q <= mem[{pix_y[8:4], pix_x[9:3]}];
  end

  assign font_addr = {ram_q, y_p1};
  assign pix_bit   = font_data[3'd7 - x_p2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_p1       <= '0;
      y_p1       <= '0;
      vld_p1     <= 1'b0;
      x_p2       <= '0;
      vld_p2     <= 1'b0;
      text_on    <= 1'b0;
      rgb        <= '0;
      video_on_d <= 1'b0;
    end else begin
      x_p1       <= pix_x[2:0];
      y_p1       <= pix_y[3:0];
      vld_p1     <= video_on;
      // Stage p1 -> p2: font ROM read in flight.
      x_p2       <= x_p1;
      vld_p2     <= vld_p1;
      // Stage p2 -> out: pick the glyph bit and colour it.
      video_on_d <= vld_p2;
      text_on    <= vld_p2 & pix_bit;
      rgb        <= !vld_p2 ? 12'h000 : (pix_bit ? FG_COLOR : BG_COLOR);
    end
  end

endmodule

// File: tb/tb_text_tile_gen.sv
// Randomized bench for text_tile_gen: shadow tile buffer, cursor model and
// a font ROM model drive expected render output and cursor behaviour.
module tb_text_tile_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pix_x, pix_y;
  logic        video_on;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        wr_en;
  logic [6:0]  wr_char;
  logic        set_cur;
  logic [6:0]  cur_col_in;
  logic [4:0]  cur_row_in;
  logic        clr_req;
  logic        busy;
  logic [6:0]  cur_col;
  logic [4:0]  cur_row;
  logic        text_on;
  logic [11:0] rgb;
  logic        video_on_d;

  logic [7:0] font_rom [0:2047];
  logic [6:0] shadow [0:29][0:79];
  int m_col, m_row;
  int n_vec = 0;
  int n_err = 0;

  text_tile_gen dut (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y), .video_on(video_on),
    .font_addr(font_addr), .font_data(font_data), .wr_en(wr_en), .wr_char(wr_char),
    .set_cur(set_cur), .cur_col_in(cur_col_in), .cur_row_in(cur_row_in),
    .clr_req(clr_req), .busy(busy), .cur_col(cur_col), .cur_row(cur_row),
    .text_on(text_on), .rgb(rgb), .video_on_d(video_on_d)
  );

  always #5 clk = ~clk;

  // Font ROM: one-cycle registered read.
  always @(posedge clk) font_data <= font_rom[font_addr];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] exp_addr(input int x, input int y);
    return {shadow[y / 16][x / 8], 4'(y % 16)};
  endfunction

  // Expected {text_on, video_on_d, rgb} for a pixel.
  function automatic logic [13:0] exp_pix(input int x, input int y, input bit v);
    logic [7:0] row_bits;
    bit on;
    row_bits = font_rom[exp_addr(x, y)];
    on = v && row_bits[7 - (x % 8)];
    return {on, v, (v ? (on ? 12'hFFF : 12'h000) : 12'h000)};
  endfunction

  task automatic check_cursor(input string tag);
    check({tag, "_col"}, cur_col, m_col);
    check({tag, "_row"}, cur_row, m_row);
  endtask

  task automatic do_op(input bit we, input bit sc, input logic [6:0] ch, input int c, input int r);
    wr_en = we; set_cur = sc; wr_char = ch;
    cur_col_in = 7'(c); cur_row_in = 5'(r);
    step();
    wr_en = 0; set_cur = 0;
    if (sc) begin
      m_col = (c > 79) ? 79 : c;
      m_row = (r > 29) ? 29 : r;
    end else if (we) begin
      shadow[m_row][m_col] = ch;
      m_col++;
      if (m_col == 80) begin
        m_col = 0;
        m_row = (m_row == 29) ? 0 : m_row + 1;
      end
    end
    check_cursor("op_cursor");
  endtask

  task automatic check_cell(input int c, input int r, input logic [6:0] ch);
    int y;
    y = r * 16 + int'($urandom_range(0, 15));
    pix_x = 10'(c * 8 + int'($urandom_range(0, 7)));
    pix_y = 10'(y);
    video_on = 1;
    step();
    check("cell_addr", font_addr, {ch, 4'(y % 16)});
  endtask

  task automatic do_clear(input bit poke);
    int cnt;
    clr_req = 1;
    step();
    clr_req = 0;
    check("clear_busy", busy, 1);
    cnt = 1;
    while (busy && cnt < 3000) begin
      if (poke) begin
        wr_en = 1; wr_char = 7'h55; set_cur = 1; cur_col_in = 7'd10; cur_row_in = 5'd10;
      end
      step();
      if (busy) cnt++;
    end
    wr_en = 0; set_cur = 0;
    check("clear_cycles", cnt, 2400);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) shadow[r][c] = 7'h20;
    m_col = 0; m_row = 0;
    check_cursor("clear_cursor");
  endtask

  int qx[$], qy[$];
  bit qv[$];

  task automatic render_run();
    logic [13:0] expq[$];
    logic [13:0] e;
    int n;
    n = qx.size();
    for (int i = 0; i < n + 2; i++) begin
      int x, y;
      bit v;
      if (i < n) begin x = qx[i]; y = qy[i]; v = qv[i]; end
      else begin x = 0; y = 0; v = 0; end
      pix_x = 10'(x); pix_y = 10'(y); video_on = v;
      expq.push_back(exp_pix(x, y, v));
      e = {3'b0, exp_addr(x, y)};
      step();
      check("font_addr", font_addr, e);
      if (i >= 2) begin
        e = expq.pop_front();
        check("text_on", text_on, e[13]);
        check("video_on_d", video_on_d, e[12]);
        check("rgb", rgb, e[11:0]);
      end
    end
  endtask

  initial begin
    logic [10:0] a;
    for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
    pix_x = 0; pix_y = 0; video_on = 0; wr_en = 0; wr_char = 0; set_cur = 0;
    cur_col_in = 0; cur_row_in = 0; clr_req = 0;
    m_col = 0; m_row = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check_cursor("rst_cursor");
    check("rst_text_on", text_on, 0);
    check("rst_rgb", rgb, 0);
    check("rst_vod", video_on_d, 0);
    check("rst_font_addr", font_addr, 0);
    reset = 0;
    step();

    do_clear(0);
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 80; c++) check_cell(c, r, 7'h20);

    // Directed write and render of 'A'
    do_op(0, 1, 7'h00, 5, 2);
    do_op(1, 0, 7'h41, 0, 0);
    check("dir_col", cur_col, 6);
    check("dir_row", cur_row, 2);
    font_rom[11'h415] = 8'b1000_0000;
    pix_x = 40; pix_y = 37; video_on = 1;
    step();
    check("dir_font_addr", font_addr, 11'h415);
    pix_x = 41;
    step();
    video_on = 0;
    step();
    check("dir_on_text", text_on, 1);
    check("dir_on_rgb", rgb, 12'hFFF);
    step();
    check("dir_off_text", text_on, 0);
    check("dir_off_rgb", rgb, 12'h000);
    check("dir_off_vod", video_on_d, 1);

    // Last-cell write wraps cursor
    do_op(0, 1, 7'h00, 79, 29);
    do_op(1, 0, 7'h33, 0, 0);
    check("wrap_col", cur_col, 0);
    check("wrap_row", cur_row, 0);
    check_cell(79, 29, 7'h33);

    // Clamp and priority
    do_op(0, 1, 7'h00, 100, 31);
    do_op(1, 1, 7'h44, 3, 4);
    check_cell(79, 29, 7'h33);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       do_op(0, 1, 7'($urandom), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)));
        3:       do_op(1, 1, 7'($urandom), int'($urandom_range(0, 127)), int'($urandom_range(0, 31)));
        default: do_op(1, 0, 7'($urandom), 0, 0);
      endcase
    end

    qx.delete(); qy.delete(); qv.delete();
    for (int i = 0; i < 400; i++) begin
      qx.push_back(int'($urandom_range(0, 639)));
      qy.push_back(int'($urandom_range(0, 479)));
      qv.push_back(($urandom_range(0, 3) != 0));
    end
    render_run();

    // Blanked video with an all-ones glyph row
    a = exp_addr(24, 48);
    font_rom[a] = 8'hFF;
    pix_x = 24; pix_y = 48; video_on = 0;
    step(); step(); step();
    check("blank_rgb", rgb, 0);
    check("blank_text_on", text_on, 0);
    check("blank_vod", video_on_d, 0);

    do_clear(1);
    check_cell(10, 10, 7'h20);
    check_cell(0, 0, 7'h20);
    check_cell(79, 29, 7'h20);

    // Reset in the middle of a clear
    pix_x = 8; pix_y = 16; video_on = 1;
    clr_req = 1;
    step();
    clr_req = 0;
    repeat (99) step();
    check("mid_busy_pre", busy, 1);
    check("mid_vod_pre", video_on_d, 1);
    #2 reset = 1;
    #1;
    check("mid_busy", busy, 0);
    check("mid_rgb", rgb, 0);
    check("mid_text_on", text_on, 0);
    check("mid_vod", video_on_d, 0);
    m_col = 0; m_row = 0;
    check_cursor("mid_cursor");
    #2 reset = 0;
    step();
    do_op(1, 0, 7'h5A, 0, 0);
    check_cell(0, 0, 7'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
